// File: rtl/step_counter_mod.sv
// Registered up/down counter modulo MAX+1 with programmable step, load, wrap/saturate.
// Latency: q_out/wrap_out/ovf_out update one edge after inputs are sampled; max_out/zero_out are combinational.
// Backpressure: none; a new operation is accepted on every rising edge.
module step_counter_mod #(
  parameter int N   = 5,
  parameter int MAX = 2**N - 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en_in,
  input  logic         up_in,
  input  logic         sat_in,
  input  logic [N-1:0] step_in,
  input  logic         load_in,
  input  logic [N-1:0] d_in,
  input  logic         clr_in,
  output logic [N-1:0] q_out,
  output logic         wrap_out,
  output logic         ovf_out,
  output logic         max_out,
  output logic         zero_out
);

  localparam logic [N-1:0] MAX_N = MAX[N-1:0];
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};
  // Modulus in N bits; wraps to 0 when MAX = 2**N-1, which is still correct
  // because every result below is formed modulo 2**N and lands in [0, MAX].
  localparam logic [N-1:0] MOD_N = MAX_N + ONE_N;
  localparam logic [N:0]   MAX_E = {1'b0, MAX_N};

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         ovf_q, ovf_d;
  logic [N-1:0] s_n;
  logic [N:0]   t_up;

  // Next-state: load beats count beats hold; step/direction only looked at when counting.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    s_n    = '0;
    t_up   = '0;
    if (load_in) begin
      q_d = (d_in > MAX_N) ? MAX_N : d_in;
    end else if (en_in) begin
      s_n = (step_in > MAX_N) ? MAX_N : step_in;
      if (up_in) begin
        t_up = {1'b0, q_q} + {1'b0, s_n};
        if (t_up > MAX_E) begin
          wrap_d = 1'b1;
          q_d    = sat_in ? MAX_N : (q_q + s_n - MOD_N);
        end else begin
          q_d = q_q + s_n;
        end
      end else begin
        if (q_q >= s_n) begin
          q_d = q_q - s_n;
        end else begin
          wrap_d = 1'b1;
          q_d    = sat_in ? '0 : (q_q + MOD_N - s_n);
        end
      end
    end
    // A crossing on this edge wins over a clear on the same edge.
    ovf_d = wrap_d | (ovf_q & ~clr_in);
  end

  // State registers with asynchronous reset to zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q_out    = q_q;
  assign wrap_out = wrap_q;
  assign ovf_out  = ovf_q;
  assign max_out  = (q_q == MAX_N);
  assign zero_out = (q_q == '0);

endmodule

// File: tb/tb_step_counter_mod.sv
module tb_step_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // Instance A: N=5, MAX=23
  logic       a_en, a_up, a_sat, a_load, a_clr;
  logic [4:0] a_step, a_d, a_q;
  logic       a_wrap, a_ovf, a_max, a_zero;
  // Instance B: N=4, MAX=15 (full modulus)
  logic       b_en, b_up, b_sat, b_load, b_clr;
  logic [3:0] b_step, b_d, b_q;
  logic       b_wrap, b_ovf, b_max, b_zero;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    int q;
    bit wrap;
    bit ovf;
  } exp_t;
  exp_t sbq[$];

  step_counter_mod #(.N(5), .MAX(23)) dut_a (
    .clk_in(clk), .rst_in(rst), .en_in(a_en), .up_in(a_up), .sat_in(a_sat),
    .step_in(a_step), .load_in(a_load), .d_in(a_d), .clr_in(a_clr),
    .q_out(a_q), .wrap_out(a_wrap), .ovf_out(a_ovf), .max_out(a_max), .zero_out(a_zero)
  );

  step_counter_mod #(.N(4), .MAX(15)) dut_b (
    .clk_in(clk), .rst_in(rst), .en_in(b_en), .up_in(b_up), .sat_in(b_sat),
    .step_in(b_step), .load_in(b_load), .d_in(b_d), .clr_in(b_clr),
    .q_out(b_q), .wrap_out(b_wrap), .ovf_out(b_ovf), .max_out(b_max), .zero_out(b_zero)
  );

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_ctrl(input bit load, input bit en, input bit up, input bit sat,
                        input int step, input int d, input bit clr);
    a_load = load; a_en = en; a_up = up; a_sat = sat;
    a_step = 5'(step); a_d = 5'(d); a_clr = clr;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    a_ctrl(0, 0, 1, 0, 0, 0, 0);
    b_load = 0; b_en = 0; b_up = 1; b_sat = 0; b_step = 4'd1; b_d = 4'd0; b_clr = 0;
    tick(); tick();
    ntests++;
    if (a_q !== 5'd0 || a_wrap !== 1'b0 || a_ovf !== 1'b0 || a_zero !== 1'b1 ||
        b_q !== 4'd0 || b_zero !== 1'b1) begin
      nfail++;
      $display("FAIL reset_initial: a_q=%0d wrap=%b ovf=%b zero=%b b_q=%0d, need 0/0/0/1 b_q=0",
               a_q, a_wrap, a_ovf, a_zero, b_q);
    end
    rst = 1'b0;
    // Build non-trivial state: q=22, then 22+5 -> 3 with wrap and ovf.
    a_ctrl(1, 0, 1, 0, 0, 22, 0); sbq.push_back('{22, 0, 0});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL reset_prep_load: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    a_ctrl(0, 1, 1, 0, 5, 0, 0); sbq.push_back('{3, 1, 1});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL reset_prep_wrap: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    // Assert reset between edges: must clear at once.
    #2 rst = 1'b1;
    #1;
    ntests++;
    if (a_q !== 5'd0 || a_wrap !== 1'b0 || a_ovf !== 1'b0 || a_zero !== 1'b1) begin
      nfail++; $display("FAIL reset_async: q=%0d w=%b o=%b z=%b need 0/0/0/1", a_q, a_wrap, a_ovf, a_zero);
    end
    // Held through an enabled edge.
    tick();
    ntests++;
    if (a_q !== 5'd0 || a_wrap !== 1'b0 || a_ovf !== 1'b0) begin
      nfail++; $display("FAIL reset_hold: q=%0d w=%b o=%b need 0/0/0", a_q, a_wrap, a_ovf);
    end
    rst = 1'b0;
    a_ctrl(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_wrap_up();
    exp_t e;
    bit   emax[$];
    bit   m;
    a_ctrl(1, 0, 1, 0, 3, 20, 0); sbq.push_back('{20, 0, 0}); emax.push_back(0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        a_ctrl(0, 1, 1, 0, 3, 0, 0);
        sbq.push_back('{23, 0, 0}); emax.push_back(1);
        sbq.push_back('{2, 1, 1});  emax.push_back(0);
        sbq.push_back('{5, 0, 1});  emax.push_back(0);
      end else begin
        tick();
      end
      e = sbq.pop_front(); m = emax.pop_front();
      ntests++;
      if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf || a_max !== m) begin
        nfail++;
        $display("FAIL wrap_up[%0d]: q=%0d w=%b o=%b max=%b need %0d/%b/%b/%b",
                 i, a_q, a_wrap, a_ovf, a_max, e.q, e.wrap, e.ovf, m);
      end
    end
    a_ctrl(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_sat_down();
    exp_t e;
    // Load 4 with clear so ovf starts at 0.
    a_ctrl(1, 0, 0, 1, 5, 4, 1); sbq.push_back('{4, 0, 0});
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        a_ctrl(0, 1, 0, 1, 5, 0, 0);
        sbq.push_back('{0, 1, 1});
        sbq.push_back('{0, 1, 1});
      end else begin
        tick();
      end
      e = sbq.pop_front();
      ntests++;
      if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf || a_zero !== (e.q == 0)) begin
        nfail++;
        $display("FAIL sat_down[%0d]: q=%0d w=%b o=%b z=%b need %0d/%b/%b",
                 i, a_q, a_wrap, a_ovf, a_zero, e.q, e.wrap, e.ovf);
      end
    end
    a_ctrl(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_priority_clamp();
    exp_t e;
    // load and en together, d above MAX; ovf still 1 from previous test.
    a_ctrl(1, 1, 1, 0, 7, 30, 0); sbq.push_back('{23, 0, 1});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf || a_max !== 1'b1) begin
      nfail++; $display("FAIL prio_load_clamp: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    // step 31 clamps to 23: 23-23 = 0, no crossing.
    a_ctrl(0, 1, 0, 0, 31, 0, 0); sbq.push_back('{0, 0, 1});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL step_clamp: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    // step 0 down from 0 is a no-op without a crossing.
    a_ctrl(0, 1, 0, 0, 0, 0, 0); sbq.push_back('{0, 0, 1});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL step_zero: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    a_ctrl(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_ovf_clear();
    exp_t e;
    // clr alone first, then wrap down 0 -> 23 with clr on the same edge, then clr alone.
    a_ctrl(0, 0, 1, 0, 0, 0, 1); sbq.push_back('{0, 0, 0});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL ovf_pre_clear: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    a_ctrl(0, 1, 0, 0, 1, 0, 1); sbq.push_back('{23, 1, 1});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL ovf_set_wins: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    a_ctrl(0, 0, 0, 0, 1, 0, 1); sbq.push_back('{23, 0, 0});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL ovf_clear: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    a_ctrl(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_full_modulus();
    exp_t e;
    int   pulses = 0;
    // dut_b has been idle at 0 since reset.
    b_en = 1; b_up = 1; b_sat = 0; b_step = 4'd1;
    for (int i = 0; i < 16; i++) sbq.push_back('{(i + 1) % 16, (i == 15), (i == 15)});
    for (int i = 0; i < 16; i++) begin
      tick();
      e = sbq.pop_front();
      if (b_wrap === 1'b1) pulses++;
      ntests++;
      if (b_q !== 4'(e.q) || b_wrap !== e.wrap || b_ovf !== e.ovf || b_max !== (e.q == 15)) begin
        nfail++;
        $display("FAIL full_mod[%0d]: q=%0d w=%b o=%b max=%b need %0d/%b/%b",
                 i, b_q, b_wrap, b_ovf, b_max, e.q, e.wrap, e.ovf);
      end
    end
    ntests++;
    if (pulses != 1) begin
      nfail++; $display("FAIL full_mod_pulses: got %0d need 1", pulses);
    end
    b_en = 0;
  endtask

  task automatic test_random();
    exp_t e;
    int   mq, s, t, d, st;
    bit   mo, mw, ld, en, up, sat, clr;
    // Sync the model with a load+clear.
    d = $urandom_range(0, 31);
    a_ctrl(1, 0, 1, 0, 0, d, 1);
    mq = (d > 23) ? 23 : d; mo = 0;
    sbq.push_back('{mq, 0, 0});
    tick(); e = sbq.pop_front();
    ntests++;
    if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf) begin
      nfail++; $display("FAIL rand_sync: q=%0d w=%b o=%b need %0d/%b/%b", a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
    end
    for (int i = 0; i < 300; i++) begin
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1) != 0;
      sat = $urandom_range(0, 1) != 0;
      clr = ($urandom_range(0, 5) == 0);
      st  = $urandom_range(0, 31);
      d   = $urandom_range(0, 31);
      a_ctrl(ld, en, up, sat, st, d, clr);
      mw = 0;
      s  = (st > 23) ? 23 : st;
      if (ld) mq = (d > 23) ? 23 : d;
      else if (en) begin
        if (up) begin
          t = mq + s;
          if (t > 23) begin mw = 1; mq = sat ? 23 : t - 24; end
          else mq = t;
        end else begin
          if (mq < s) begin mw = 1; mq = sat ? 0 : mq + 24 - s; end
          else mq = mq - s;
        end
      end
      mo = mw | (mo & ~clr);
      sbq.push_back('{mq, mw, mo});
      tick();
      e = sbq.pop_front();
      ntests++;
      if (a_q !== 5'(e.q) || a_wrap !== e.wrap || a_ovf !== e.ovf ||
          a_max !== (e.q == 23) || a_zero !== (e.q == 0)) begin
        nfail++;
        $display("FAIL rand[%0d]: q=%0d w=%b o=%b mx=%b z=%b need %0d/%b/%b",
                 i, a_q, a_wrap, a_ovf, a_max, a_zero, e.q, e.wrap, e.ovf);
      end
    end
    a_ctrl(0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority_clamp();
    test_ovf_clear();
    test_full_modulus();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
